// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states, fault causes and the IF/ID payload.
package core_pkg;

    // Bubble encoding: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10
    } fault_cause_e;

    // IF/ID register contents, also consumed by decode
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic logic is_misaligned(logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select and fetch-fault detection for the RUN state.
module pc_next_mux
    import core_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic [31:0]  pc,
    input  logic         stall_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_target_i,
    output logic [31:0]  pc_next,
    output logic [31:0]  pc_plus4,
    output logic         kill,
    output logic         capture,
    output fault_cause_e fault
);

    logic [31:0] word_idx;
    logic        out_of_range;

    assign word_idx     = {2'b00, pc[31:2]};
    assign out_of_range = word_idx >= 32'(IMEM_DEPTH);

    // Redirect beats the range check; a range fault beats stall/advance.
    always_comb begin
        pc_plus4 = pc + 32'd4;
        pc_next  = pc;
        kill     = 1'b0;
        capture  = 1'b0;
        fault    = FC_NONE;
        if (redirect_valid_i) begin
            if (is_misaligned(redirect_target_i)) begin
                fault = FC_MISALIGN;
            end else begin
                pc_next = redirect_target_i;
                kill    = 1'b1;
            end
        end else if (out_of_range) begin
            fault = FC_RANGE;
        end else if (!stall_i) begin
            pc_next = pc_plus4;
            capture = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC generation and IF/ID pipeline register in front of a combinational IMEM.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] PC_Value,
    input  logic [31:0] Instruction,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fetch_halted_o,
    output logic [1:0]  fault_cause_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    if_id_t       if_id_q;
    fault_cause_e fault_q;
    logic         halted_q;

    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    logic         kill;
    logic         capture;
    fault_cause_e fault;

    pc_next_mux #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_next_mux (
        .pc                (pc_q),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .pc_next           (pc_next),
        .pc_plus4          (pc_plus4),
        .kill              (kill),
        .capture           (capture),
        .fault             (fault)
    );

    // Fetch FSM with PC, IF/ID and fault registers; HALT is left only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= BOOT;
            pc_q             <= RESET_VECTOR;
            if_id_q.pc       <= 32'h0000_0000;
            if_id_q.pc_plus4 <= 32'h0000_0004;
            if_id_q.instr    <= NOP_INSTR;
            if_id_q.valid    <= 1'b0;
            fault_q          <= FC_NONE;
            halted_q         <= 1'b0;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (fault != FC_NONE) begin
                        state_q       <= HALT;
                        fault_q       <= fault;
                        halted_q      <= 1'b1;
                        if_id_q.valid <= 1'b0;
                        if_id_q.instr <= NOP_INSTR;
                    end else begin
                        pc_q <= pc_next;
                        if (kill || flush_i) begin
                            if_id_q.valid <= 1'b0;
                            if_id_q.instr <= NOP_INSTR;
                        end else if (capture) begin
                            if_id_q.pc       <= pc_q;
                            if_id_q.pc_plus4 <= pc_plus4;
                            if_id_q.instr    <= Instruction;
                            if_id_q.valid    <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    assign PC_Value         = pc_q;
    assign if_id_pc_o       = if_id_q.pc;
    assign if_id_pc_plus4_o = if_id_q.pc_plus4;
    assign if_id_instr_o    = if_id_q.instr;
    assign if_id_valid_o    = if_id_q.valid;
    assign fetch_halted_o   = halted_q;
    assign fault_cause_o    = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural model plus directed literal checks.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (depth 256)
    logic        rst_n;
    logic        stall, flush, rv;
    logic [31:0] rt;
    logic [31:0] pc_v, instr_in, ifpc, ifpc4, ifinstr;
    logic        ifvalid, halted;
    logic [1:0]  cause;

    // Small DUT (depth 4), free-running
    logic        rst_s_n;
    logic [31:0] pc_s, instr_s, ifpc_s, ifpc4_s, ifinstr_s;
    logic        ifvalid_s, halted_s;
    logic [1:0]  cause_s;

    int errors = 0;
    int checks = 0;

    // Instruction memory contents: word k holds C0DE_0000 + k
    function automatic logic [31:0] imem_word(logic [31:0] a);
        return 32'hC0DE_0000 + (a >> 2);
    endfunction

    assign instr_in = imem_word(pc_v);
    assign instr_s  = imem_word(pc_s);

    fetch_stage u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall),
        .flush_i           (flush),
        .redirect_valid_i  (rv),
        .redirect_target_i (rt),
        .PC_Value          (pc_v),
        .Instruction       (instr_in),
        .if_id_pc_o        (ifpc),
        .if_id_pc_plus4_o  (ifpc4),
        .if_id_instr_o     (ifinstr),
        .if_id_valid_o     (ifvalid),
        .fetch_halted_o    (halted),
        .fault_cause_o     (cause)
    );

    fetch_stage #(
        .IMEM_DEPTH (4)
    ) u_small (
        .clk               (clk),
        .rst_n             (rst_s_n),
        .stall_i           (1'b0),
        .flush_i           (1'b0),
        .redirect_valid_i  (1'b0),
        .redirect_target_i (32'h0),
        .PC_Value          (pc_s),
        .Instruction       (instr_s),
        .if_id_pc_o        (ifpc_s),
        .if_id_pc_plus4_o  (ifpc4_s),
        .if_id_instr_o     (ifinstr_s),
        .if_id_valid_o     (ifvalid_s),
        .fetch_halted_o    (halted_s),
        .fault_cause_o     (cause_s)
    );

    // Model: phase 0 = first cycle after reset, 1 = fetching, 2 = stopped
    typedef struct {
        int          phase;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] instr;
        logic        valid;
        logic [1:0]  cause;
    } m_t;

    m_t m_main, m_small;

    function automatic m_t m_reset();
        m_t r;
        r.phase = 0;
        r.pc    = 32'h0;
        r.ipc   = 32'h0;
        r.ipc4  = 32'h4;
        r.instr = NOP;
        r.valid = 1'b0;
        r.cause = 2'b00;
        return r;
    endfunction

    function automatic m_t m_step(m_t m, logic st, logic fl, logic r_v, logic [31:0] r_t,
                                  int unsigned depth);
        m_t n = m;
        if (m.phase == 0) begin
            n.phase = 1;
        end else if (m.phase == 1) begin
            if (r_v && (r_t % 4 != 0)) begin
                n.phase = 2; n.cause = 2'b01; n.valid = 1'b0; n.instr = NOP;
            end else if (r_v) begin
                n.pc = r_t; n.valid = 1'b0; n.instr = NOP;
            end else if ((m.pc / 4) >= depth) begin
                n.phase = 2; n.cause = 2'b10; n.valid = 1'b0; n.instr = NOP;
            end else begin
                if (!st) n.pc = m.pc + 4;
                if (fl) begin
                    n.valid = 1'b0; n.instr = NOP;
                end else if (!st) begin
                    n.ipc = m.pc; n.ipc4 = m.pc + 4; n.instr = imem_word(m.pc); n.valid = 1'b1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_main <= m_reset();
        else        m_main <= m_step(m_main, stall, flush, rv, rt, 256);
    end

    always @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) m_small <= m_reset();
        else          m_small <= m_step(m_small, 1'b0, 1'b0, 1'b0, 32'h0, 4);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, m_t m, logic [31:0] p, logic [31:0] ip, logic [31:0] ip4,
                       logic [31:0] ins, logic v, logic h, logic [1:0] c);
        check({tag, ".pc"},     p,          m.pc);
        check({tag, ".ifpc"},   ip,         m.ipc);
        check({tag, ".ifpc4"},  ip4,        m.ipc4);
        check({tag, ".instr"},  ins,        m.instr);
        check({tag, ".valid"},  32'(v),     32'(m.valid));
        check({tag, ".halted"}, 32'(h),     32'(m.phase == 2));
        check({tag, ".cause"},  32'(c),     32'(m.cause));
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        cmp("main",  m_main,  pc_v, ifpc, ifpc4, ifinstr, ifvalid, halted, cause);
        cmp("small", m_small, pc_s, ifpc_s, ifpc4_s, ifinstr_s, ifvalid_s, halted_s, cause_s);
    end

    task automatic edge_n();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; rst_s_n = 1'b0;
        stall = 1'b0; flush = 1'b0; rv = 1'b0; rt = 32'h0;
        #12;
        check("rst_pc",    pc_v,          32'h0);
        check("rst_pc4",   ifpc4,         32'h4);
        check("rst_instr", ifinstr,       NOP);
        check("rst_valid", 32'(ifvalid),  32'h0);
        rst_n = 1'b1; rst_s_n = 1'b1;

        edge_n(); // E1: boot
        check("boot_valid", 32'(ifvalid), 32'h0);
        check("boot_pc",    pc_v,         32'h0);
        edge_n(); // E2
        check("e2_pc",    pc_v,    32'h4);
        check("e2_instr", ifinstr, 32'hC0DE_0000);
        check("e2_ifpc",  ifpc,    32'h0);
        edge_n(); // E3
        check("e3_pc",    pc_v,    32'h8);
        check("e3_instr", ifinstr, 32'hC0DE_0001);
        stall = 1'b1;
        edge_n(); // E4
        edge_n(); // E5
        check("stall_pc",    pc_v,    32'h8);
        check("stall_ifpc",  ifpc,    32'h4);
        check("stall_instr", ifinstr, 32'hC0DE_0001);
        stall = 1'b0;
        edge_n(); // E6
        check("e6_pc",    pc_v,    32'hC);
        check("e6_instr", ifinstr, 32'hC0DE_0002);
        check("small_halted", 32'(halted_s), 32'h1);
        check("small_cause",  32'(cause_s),  32'h2);
        check("small_pc",     pc_s,          32'h10);
        check("small_valid",  32'(ifvalid_s), 32'h0);
        rv = 1'b1; rt = 32'h40; stall = 1'b1;
        edge_n(); // E7
        check("redir_pc",    pc_v,         32'h40);
        check("redir_valid", 32'(ifvalid), 32'h0);
        rv = 1'b0; stall = 1'b0;
        edge_n(); // E8
        check("e8_instr", ifinstr, 32'hC0DE_0010);
        check("e8_ifpc",  ifpc,    32'h40);
        check("e8_pc",    pc_v,    32'h44);
        flush = 1'b1;
        edge_n(); // E9
        check("flush_valid", 32'(ifvalid), 32'h0);
        check("flush_pc",    pc_v,         32'h48);
        flush = 1'b0;
        edge_n(); // E10
        check("e10_instr", ifinstr, 32'hC0DE_0012);
        rv = 1'b1; rt = 32'h42;
        edge_n(); // E11
        check("mis_halted", 32'(halted), 32'h1);
        check("mis_cause",  32'(cause),  32'h1);
        check("mis_pc",     pc_v,        32'h4C);
        rt = 32'h100;
        edge_n(); // E12
        check("halt_pc",    pc_v,        32'h4C);
        check("halt_cause", 32'(cause),  32'h1);
        rv = 1'b0;
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
        edge_n(); // E13: boot
        edge_n(); // E14
        edge_n(); // E15
        check("rerun_pc", pc_v, 32'h8);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_pc",     pc_v,         32'h0);
        check("async_valid",  32'(ifvalid), 32'h0);
        check("async_instr",  ifinstr,      NOP);
        check("async_halted", 32'(halted),  32'h0);
        #2;
        rst_n = 1'b1;
        edge_n(); // E16: boot
        check("reboot_valid", 32'(ifvalid), 32'h0);
        edge_n(); // E17
        check("refetch_instr", ifinstr,      32'hC0DE_0000);
        check("refetch_valid", 32'(ifvalid), 32'h1);
        repeat (3) edge_n();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
